// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC generation, instruction-bus fetch with bounded outstanding requests and jump squashing.
// Optional FETCH_BYPASS_EN forwards rvalid data to IF/ID in the same cycle when the response buffer is empty.
module if_fetch_unit #(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        instr_mem_req_o,
    output logic [31:0] instr_mem_addr_o,
    input  logic        instr_mem_gnt_i,
    input  logic        instr_mem_rvalid_i,
    input  logic [31:0] instr_mem_rdata_i,
    input  logic        instr_req_i,
    output logic        instr_ready_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_addr_next_o
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING) + 2;
    localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);

    logic          run_q;
    logic          kill_q, kill_d;
    logic [31:0]   pc_q, pc_d, redir_q, redir_d;
    logic [CW-1:0] disc_q, disc_d, aq_cnt_q, aq_cnt_d, rb_cnt_q, rb_cnt_d;
    logic [PW-1:0] aq_wp_q, aq_wp_d, aq_rp_q, aq_rp_d, rb_wp_q, rb_wp_d, rb_rp_q, rb_rp_d;
    logic [31:0]   aq_q      [MAX_OUTSTANDING];
    logic [31:0]   rb_data_q [MAX_OUTSTANDING];
    logic [31:0]   rb_addr_q [MAX_OUTSTANDING];
    logic          gnt_acc, drop, resp, byp, rb_empty, push_aq, push_rb, pop_rb;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        instr_mem_req_o  = run_q & ((disc_q + aq_cnt_q + rb_cnt_q) < MAXC);
        instr_mem_addr_o = pc_q;
        rb_empty         = (rb_cnt_q == '0);
        gnt_acc          = instr_mem_req_o & instr_mem_gnt_i;
        // Discarded responses are always older than any tracked in the address queue.
        drop             = instr_mem_rvalid_i & (jump_flag_i | (disc_q != '0));
        resp             = instr_mem_rvalid_i & ~drop;
`ifdef FETCH_BYPASS_EN
        byp              = resp & rb_empty;
`else
        byp              = 1'b0;
`endif
        instr_ready_o    = ~jump_flag_i & (~rb_empty | byp);
        inst_o           = byp ? instr_mem_rdata_i : rb_data_q[rb_rp_q];
        inst_addr_o      = byp ? aq_q[aq_rp_q] : rb_addr_q[rb_rp_q];
        inst_addr_next_o = inst_addr_o + 32'd4;
        pop_rb           = instr_req_i & instr_ready_o & ~rb_empty;
        push_rb          = resp & ~(byp & instr_req_i);
        push_aq          = gnt_acc & ~kill_q & ~jump_flag_i;
        disc_d           = jump_flag_i ? disc_q + aq_cnt_q + CW'(gnt_acc) - CW'(instr_mem_rvalid_i)
                                       : disc_q + CW'(gnt_acc & kill_q) - CW'(instr_mem_rvalid_i & (disc_q != '0));
        aq_cnt_d         = jump_flag_i ? '0 : aq_cnt_q + CW'(push_aq) - CW'(resp);
        rb_cnt_d         = jump_flag_i ? '0 : rb_cnt_q + CW'(push_rb) - CW'(pop_rb);
        aq_wp_d          = jump_flag_i ? '0 : (push_aq ? inc(aq_wp_q) : aq_wp_q);
        aq_rp_d          = jump_flag_i ? '0 : (resp ? inc(aq_rp_q) : aq_rp_q);
        rb_wp_d          = jump_flag_i ? '0 : (push_rb ? inc(rb_wp_q) : rb_wp_q);
        rb_rp_d          = jump_flag_i ? '0 : (pop_rb ? inc(rb_rp_q) : rb_rp_q);
        // An ungranted request keeps its address; the target is parked until that grant.
        kill_d           = jump_flag_i ? (instr_mem_req_o & ~instr_mem_gnt_i) : (kill_q & ~gnt_acc);
        redir_d          = jump_flag_i ? jump_addr_i : redir_q;
        pc_d             = jump_flag_i ? (kill_d ? pc_q : jump_addr_i)
                         : gnt_acc     ? (kill_q ? redir_q : pc_q + 32'd4)
                         : pc_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q    <= 1'b0;
            kill_q   <= 1'b0;
            pc_q     <= BOOT_ADDR;
            redir_q  <= BOOT_ADDR;
            disc_q   <= '0;
            aq_cnt_q <= '0;
            rb_cnt_q <= '0;
            aq_wp_q  <= '0;
            aq_rp_q  <= '0;
            rb_wp_q  <= '0;
            rb_rp_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                aq_q[i]      <= '0;
                rb_data_q[i] <= '0;
                rb_addr_q[i] <= '0;
            end
        end else begin
            run_q    <= 1'b1;
            kill_q   <= kill_d;
            pc_q     <= pc_d;
            redir_q  <= redir_d;
            disc_q   <= disc_d;
            aq_cnt_q <= aq_cnt_d;
            rb_cnt_q <= rb_cnt_d;
            aq_wp_q  <= aq_wp_d;
            aq_rp_q  <= aq_rp_d;
            rb_wp_q  <= rb_wp_d;
            rb_rp_q  <= rb_rp_d;
            if (push_aq)
                aq_q[aq_wp_q] <= pc_q;
            if (push_rb) begin
                rb_data_q[rb_wp_q] <= instr_mem_rdata_i;
                rb_addr_q[rb_wp_q] <= aq_q[aq_rp_q];
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for if_fetch_unit with a latency-programmable instruction memory.
// Memory returns ~addr as data; expected instructions are pushed per scenario and popped by the monitor.
`timescale 1ns/1ps
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        instr_req = 1'b0;
    logic        instr_ready;
    logic [31:0] inst, inst_addr, inst_addr_next;

    typedef struct { logic [31:0] addr; logic [31:0] next; } exp_t;
    typedef struct { logic [31:0] addr; int due; } rsp_t;
    exp_t        exp_q[$];
    rsp_t        mem_q[$];
    logic [31:0] glog[$];
    int          gcyc[$];
    int cyc = 0, xcnt = 0, xfirst = -1, lat = 1, tests = 0, fails = 0;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
    localparam int GSPAN = 2;
`else
    localparam int LAT = 2;
    localparam int GSPAN = 3;
`endif

    if_fetch_unit dut (
        .clk_i(clk), .rst_ni(rst_n),
        .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .instr_mem_req_o(mem_req), .instr_mem_addr_o(mem_addr),
        .instr_mem_gnt_i(mem_gnt), .instr_mem_rvalid_i(mem_rvalid), .instr_mem_rdata_i(mem_rdata),
        .instr_req_i(instr_req), .instr_ready_o(instr_ready),
        .inst_o(inst), .inst_addr_o(inst_addr), .inst_addr_next_o(inst_addr_next)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic expect_x(input logic [31:0] a, input logic [31:0] nx);
        exp_q.push_back('{a, nx});
    endtask

    task automatic clear_state();
        exp_q.delete();
        glog.delete();
        gcyc.delete();
        mem_q.delete();
        xfirst = -1;
    endtask

    task automatic do_reset(input int l, input logic g);
        @(posedge clk); #1;
        rst_n = 1'b0; jump_flag = 1'b0; instr_req = 1'b0; lat = l; mem_gnt = g;
        clear_state();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic consume(input int n);
        int tgt;
        int t;
        tgt = xcnt + n;
        t = 0;
        instr_req = 1'b1;
        while (xcnt < tgt && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        instr_req = 1'b0;
        chk("xfer_count", 32'(xcnt), 32'(tgt));
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: in order, fixed latency per grant.
    initial forever begin
        @(posedge clk); #1;
        if (!rst_n) begin
            mem_rvalid = 1'b0;
            mem_q.delete();
        end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata = ~mem_q[0].addr;
            void'(mem_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_req && mem_gnt) begin
                    glog.push_back(mem_addr);
                    gcyc.push_back(cyc);
                    mem_q.push_back('{mem_addr, cyc + lat});
                end
                if (instr_ready && instr_req) begin
                    xcnt++;
                    if (xfirst < 0) xfirst = cyc;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_xfer: got addr %h, want none", inst_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("inst_addr", inst_addr, e.addr);
                        chk("inst_addr_next", inst_addr_next, e.next);
                        chk("inst_data", inst, ~e.addr);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal;
    end

    initial begin
        int t;
        @(posedge clk); #1;
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_ready", {31'b0, instr_ready}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_addr", inst_addr, 32'h0);
        chk("rst_inst_next", inst_addr_next, 32'h4);

        // Boot stream with 1-cycle memory and IF/ID always accepting.
        expect_x(32'h0, 32'h4); expect_x(32'h4, 32'h8);
        expect_x(32'h8, 32'hC); expect_x(32'hC, 32'h10);
        rst_n = 1'b1;
        consume(4);
        chk("boot_g0", glog[0], 32'h0);
        chk("boot_g1", glog[1], 32'h4);
        chk("boot_g2", glog[2], 32'h8);
        chk("first_latency", 32'(xfirst - gcyc[0]), 32'(LAT));
        chk("grant_span", 32'(gcyc[2] - gcyc[0]), 32'(GSPAN));

        // Stall: issue stops at two outstanding, then the stream resumes in order.
        do_reset(1, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stall_grants", 32'(glog.size()), 32'd2);
        chk("stall_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        expect_x(32'h0, 32'h4); expect_x(32'h4, 32'h8);
        expect_x(32'h8, 32'hC); expect_x(32'hC, 32'h10);
        consume(4);

        // Jump with two requests in flight on a 3-cycle memory.
        do_reset(3, 1'b1);
        t = 0;
        while (glog.size() < 2 && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        chk("inflight_grants", 32'(glog.size()), 32'd2);
        @(posedge clk); #1;
        expect_x(32'h100, 32'h104); expect_x(32'h104, 32'h108);
        jump_flag = 1'b1; jump_addr = 32'h100; instr_req = 1'b1;
        @(posedge clk); #1 jump_flag = 1'b0;
        consume(2);
        chk("jump_target_addr", glog[2], 32'h100);

        // Jump coinciding with both a grant and an rvalid.
        do_reset(1, 1'b1);
        t = 0;
        do begin
            @(posedge clk); #2;
            t++;
        end while (!(mem_req && mem_gnt && mem_rvalid) && t < 20);
        chk("sync_point", {31'b0, mem_req & mem_gnt & mem_rvalid}, 32'd1);
        expect_x(32'h200, 32'h204); expect_x(32'h204, 32'h208); expect_x(32'h208, 32'h20C);
        jump_flag = 1'b1; jump_addr = 32'h200; instr_req = 1'b1;
        @(negedge clk);
        chk("ready_in_jump", {31'b0, instr_ready}, 32'd0);
        @(posedge clk); #1 jump_flag = 1'b0;
        consume(3);
        chk("sync_jump_addr", glog[2], 32'h200);

        // PC wrap at the top of the address space.
        do_reset(1, 1'b1);
        expect_x(32'hFFFF_FFF8, 32'hFFFF_FFFC); expect_x(32'hFFFF_FFFC, 32'h0);
        expect_x(32'h0, 32'h4); expect_x(32'h4, 32'h8);
        jump_flag = 1'b1; jump_addr = 32'hFFFF_FFF8; instr_req = 1'b1;
        @(posedge clk); #1 jump_flag = 1'b0;
        consume(4);
        chk("wrap_g0", glog[0], 32'hFFFF_FFF8);
        chk("wrap_g1", glog[1], 32'hFFFF_FFFC);
        chk("wrap_g2", glog[2], 32'h0);

        // Asynchronous reset with a full buffer.
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("full_ready", {31'b0, instr_ready}, 32'd1);
        chk("full_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_state();
        #1;
        chk("async_ready", {31'b0, instr_ready}, 32'd0);
        chk("async_req", {31'b0, mem_req}, 32'd0);
        chk("async_inst_addr", inst_addr, 32'h0);
        chk("async_inst_next", inst_addr_next, 32'h4);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_x(32'h0, 32'h4); expect_x(32'h4, 32'h8);
        consume(2);
        chk("restart_addr", glog[0], 32'h0);

        // Jump while a request waits for grant: it stays on the bus and its data is dropped.
        do_reset(1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pend_req", {31'b0, mem_req}, 32'd1);
        chk("pend_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        jump_flag = 1'b1; jump_addr = 32'h300;
        @(posedge clk); #1 jump_flag = 1'b0;
        @(negedge clk);
        chk("pend_hold_req", {31'b0, mem_req}, 32'd1);
        chk("pend_hold_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        expect_x(32'h300, 32'h304); expect_x(32'h304, 32'h308);
        consume(2);
        chk("pend_g0", glog[0], 32'h0);
        chk("pend_g1", glog[1], 32'h300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
